// File: rtl/aes_job_sequencer.sv
// Round-robin job sequencer in front of the AES_top core: grants host/trace jobs, drives AES_en/data/key,
// and returns ciphertext with id and latency. Optional RUN watchdog under `AES_SEQ_TIMEOUT_EN.
module aes_job_sequencer #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int LAT_W          = 8
) (
  input  logic             AES_clk,
  input  logic             AES_rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [127:0]     req0_data,
  input  logic [127:0]     req1_data,
  input  logic [127:0]     req0_key,
  input  logic [127:0]     req1_key,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [127:0]     res_data,
  output logic [LAT_W-1:0] res_lat,
  output logic             res_err,
  output logic             aes_en,
  output logic [127:0]     aes_data,
  output logic [127:0]     aes_key,
  input  logic [127:0]     aes_out,
  input  logic             aes_out_valid,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int              GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LD  = GW'(GAP_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

  // Both counts must be at least one for the FSM to make forward progress.
  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("aes_job_sequencer: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             cur_id_q, cur_id_d;
  logic [1:0]       req_ready_q, req_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [127:0]     res_data_q, res_data_d;
  logic [LAT_W-1:0] res_lat_q, res_lat_d;
  logic             aes_en_q, aes_en_d;
  logic [127:0]     aes_data_q, aes_data_d;
  logic [127:0]     aes_key_q, aes_key_d;
  logic             busy_q, busy_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic             gnt_id;
  logic             acc;
  logic             acc_id;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int               TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    TO_CNT = TW'(TIMEOUT_CYCLES);
  localparam logic [LAT_W-1:0] TO_LAT = (TIMEOUT_CYCLES > (2**LAT_W) - 1) ? LAT_MAX
                                                                           : LAT_W'(TIMEOUT_CYCLES);
  logic          res_err_q, res_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Pointer requester wins if it asks; otherwise the other one.
  assign gnt_id = req_valid[ptr_q] ? ptr_q : ~ptr_q;
  // A job is taken only against a ready that was registered in an earlier IDLE cycle.
  assign acc    = (state_q == S_IDLE) && |(req_valid & req_ready_q);
  assign acc_id = req_ready_q[1];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    req_ready_d = 2'b00;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_lat_d   = res_lat_q;
    aes_en_d    = aes_en_q;
    aes_data_d  = aes_data_q;
    aes_key_d   = aes_key_q;
    lat_d       = lat_q;
    gap_d       = gap_q;
`ifdef AES_SEQ_TIMEOUT_EN
    res_err_d   = res_err_q;
    tmo_d       = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d    = S_RUN;
          cur_id_d   = acc_id;
          ptr_d      = ~acc_id;
          aes_data_d = acc_id ? req1_data : req0_data;
          aes_key_d  = acc_id ? req1_key  : req0_key;
          aes_en_d   = 1'b1;
          lat_d      = LAT_W'(1);
`ifdef AES_SEQ_TIMEOUT_EN
          tmo_d      = TW'(1);
`endif
        end else if (|req_valid) begin
          req_ready_d = gnt_id ? 2'b10 : 2'b01;
        end
      end

      S_RUN: begin
        if (aes_out_valid) begin
          state_d     = S_HOLD;
          res_valid_d = 1'b1;
          res_id_d    = cur_id_q;
          res_data_d  = aes_out;
          res_lat_d   = lat_q;
          aes_en_d    = 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
          res_err_d   = 1'b0;
        end else if (tmo_q == TO_CNT) begin
          state_d     = S_HOLD;
          res_valid_d = 1'b1;
          res_id_d    = cur_id_q;
          res_data_d  = '0;
          res_lat_d   = TO_LAT;
          res_err_d   = 1'b1;
          aes_en_d    = 1'b0;
`endif
        end else begin
          if (lat_q != LAT_MAX) lat_d = lat_q + 1'b1;
`ifdef AES_SEQ_TIMEOUT_EN
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end

      S_HOLD: begin
        if (res_ready) begin
          state_d     = S_GAP;
          res_valid_d = 1'b0;
          gap_d       = GAP_LD;
`ifdef AES_SEQ_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end
      end

      default: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      cur_id_q    <= 1'b0;
      req_ready_q <= 2'b00;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      res_lat_q   <= '0;
      aes_en_q    <= 1'b0;
      aes_data_q  <= '0;
      aes_key_q   <= '0;
      busy_q      <= 1'b0;
      lat_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_lat_q   <= res_lat_d;
      aes_en_q    <= aes_en_d;
      aes_data_q  <= aes_data_d;
      aes_key_q   <= aes_key_d;
      busy_q      <= busy_d;
      lat_q       <= lat_d;
      gap_q       <= gap_d;
    end
  end

`ifdef AES_SEQ_TIMEOUT_EN
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      res_err_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      res_err_q <= res_err_d;
      tmo_q     <= tmo_d;
    end
  end
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_lat   = res_lat_q;
  assign aes_en    = aes_en_q;
  assign aes_data  = aes_data_q;
  assign aes_key   = aes_key_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer with a behavioural core of programmable latency.
module tb_aes_job_sequencer;
  localparam int LAT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [127:0]     req0_data = '0, req1_data = '0, req0_key = '0, req1_key = '0;
  logic             res_valid, res_ready = 1'b0, res_id, res_err;
  logic [127:0]     res_data;
  logic [LAT_W-1:0] res_lat;
  logic             aes_en, busy;
  logic [127:0]     aes_data, aes_key, aes_out;
  logic             aes_out_valid;

  logic             core_vld = 1'b0, core_off = 1'b0, inj_vld = 1'b0;
  logic [127:0]     core_out = '0, inj_data = '0;
  int               core_lat = 2, ccnt = 0;
  int               n_vec = 0, n_err = 0;
  int               lowrun = 0, last_low = 0;

  assign aes_out_valid = core_vld | inj_vld;
  assign aes_out       = inj_vld ? inj_data : core_out;

  always #5 clk = ~clk;

  aes_job_sequencer #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(16), .LAT_W(LAT_W)) dut (
    .AES_clk(clk), .AES_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_data(req0_data), .req1_data(req1_data), .req0_key(req0_key), .req1_key(req1_key),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .res_lat(res_lat), .res_err(res_err),
    .aes_en(aes_en), .aes_data(aes_data), .aes_key(aes_key),
    .aes_out(aes_out), .aes_out_valid(aes_out_valid), .busy(busy)
  );

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  // Core stand-in: raises valid for one cycle in the core_lat-th cycle of AES_en.
  always @(posedge clk) begin
    core_vld <= 1'b0;
    if (!aes_en) ccnt <= 0;
    else begin
      ccnt <= ccnt + 1;
      if (!core_off && ccnt == core_lat - 2) begin
        core_vld <= 1'b1;
        core_out <= core_fn(aes_data, aes_key);
      end
    end
  end

  // Length of the most recent AES_en-low stretch between two jobs.
  always @(negedge clk) begin
    if (aes_en) begin
      if (lowrun > 0) last_low = lowrun;
      lowrun = 0;
    end else lowrun = lowrun + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0; inj_vld = 1'b0; core_off = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for launch, checks the launched operands, then the result and AES_en high time.
  task automatic collect(input string tag, input logic id, input logic [127:0] din,
                         input logic [127:0] key, input int lat);
    int n, hi;
    core_lat = lat;
    n = 0;
    while (!aes_en && n < 50) begin @(negedge clk); n++; end
    chk({tag, " launch"}, 128'(n < 50), 128'(1));
    chk({tag, " aes_data"}, aes_data, din);
    chk({tag, " aes_key"}, aes_key, key);
    hi = 0; n = 0;
    while (!res_valid && n < 200) begin hi += int'(aes_en); @(negedge clk); n++; end
    chk({tag, " res_valid"}, 128'(res_valid), 128'(1));
    chk({tag, " res_id"}, 128'(res_id), 128'(id));
    chk({tag, " res_data"}, res_data, core_fn(din, key));
    chk({tag, " res_lat"}, 128'(res_lat), 128'(lat));
    chk({tag, " res_err"}, 128'(res_err), 128'(0));
    chk({tag, " aes_en off"}, 128'(aes_en), 128'(0));
    chk({tag, " en cycles"}, 128'(hi), 128'(lat));
  endtask

  task automatic ack(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, " res_valid drop"}, 128'(res_valid), 128'(0));
    chk({tag, " busy in gap"}, 128'(busy), 128'(1));
  endtask

  localparam logic [127:0] D1A = 128'h000000db_00000000_00000000_00000000;
  localparam logic [127:0] K1  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] D2A = 128'hd7b26248_e8351227_5573a1e5_e8f263b3;
  localparam logic [127:0] D2B = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
  localparam logic [127:0] D4  = 128'hf301a68a_9e9ffa50_844581d9_e290d818;

  initial begin
    int bad;
    int lats[4];
    logic [127:0] d;
    lats[0] = 2; lats[1] = 3; lats[2] = 4; lats[3] = 7;

    // Reset state
    reset_dut();
    chk("rst req_ready", 128'(req_ready), 128'(0));
    chk("rst res_valid", 128'(res_valid), 128'(0));
    chk("rst aes_en", 128'(aes_en), 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst aes_data", aes_data, 128'(0));
    chk("rst res_lat", 128'(res_lat), 128'(0));
    chk("rst res_err", 128'(res_err), 128'(0));

    // T1: single host job
    req0_data = D1A; req0_key = K1; req_valid = 2'b01;
    @(negedge clk);
    chk("t1 ready", 128'(req_ready), 128'(2'b01));
    chk("t1 idle en", 128'(aes_en), 128'(0));
    @(negedge clk);
    req_valid = 2'b00;
    chk("t1 ready 1cyc", 128'(req_ready), 128'(0));
    collect("t1", 1'b0, D1A, K1, 5);
    ack("t1");
    @(negedge clk);
    chk("t1 gap2 busy", 128'(busy), 128'(1));
    @(negedge clk);
    chk("t1 idle busy", 128'(busy), 128'(0));
    chk("t1 data held", aes_data, D1A);

    // T6a: stray core valid in IDLE
    inj_data = 128'hdead; inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    @(negedge clk);
    chk("t6 idle res_valid", 128'(res_valid), 128'(0));
    chk("t6 idle busy", 128'(busy), 128'(0));

    // T2: both requesters continuously valid -> strict alternation
    reset_dut();
    req0_data = D2A; req1_data = D2B; req0_key = K1; req1_key = K1;
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      d = j[0] ? D2B : D2A;
      collect($sformatf("t2 job%0d", j), j[0], d, K1, lats[j]);
      if (j == 3) req_valid = 2'b00;
      if (j > 0) chk($sformatf("t2 gap%0d>=3", j), 128'(last_low >= 3), 128'(1));
      ack($sformatf("t2 job%0d", j));
    end
    repeat (3) @(negedge clk);
    chk("t2 no extra job", 128'(busy), 128'(0));

    // T3: stalled consumer; other requester pending; stray valid in HOLD
    req0_data = D1A ^ 128'h55; req_valid = 2'b01;
    collect("t3", 1'b0, D1A ^ 128'h55, K1, 3);
    req_valid = 2'b10;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      inj_vld = (i == 5); inj_data = 128'hbeef;
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== core_fn(D1A ^ 128'h55, K1) || res_lat !== 8'd3 ||
          req_ready !== 2'b00 || aes_en !== 1'b0) bad++;
    end
    inj_vld = 1'b0;
    chk("t3 hold stable", 128'(bad), 128'(0));
    req_valid = 2'b00;
    ack("t3");
    inj_vld = 1'b1; inj_data = 128'hf00d;
    @(negedge clk);
    inj_vld = 1'b0;
    chk("t6 gap res_valid", 128'(res_valid), 128'(0));
    @(negedge clk);
    chk("t3 back idle", 128'(busy), 128'(0));
    chk("t6 gap no result", 128'(res_valid), 128'(0));

    // T4: reset during RUN
    reset_dut();
    core_off = 1'b1; req0_data = D2A; req0_key = K1; req_valid = 2'b01;
    bad = 0;
    while (!aes_en && bad < 20) begin @(negedge clk); bad++; end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("t4 running", 128'(aes_en & busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t4 async en", 128'(aes_en), 128'(0));
    chk("t4 async busy", 128'(busy), 128'(0));
    chk("t4 async res_valid", 128'(res_valid), 128'(0));
    chk("t4 async aes_data", aes_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1; core_off = 1'b0;
    req1_data = D4; req1_key = K1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("t4 ptr reset", 128'(req_ready), 128'(2'b01));
    req_valid = 2'b10;
    @(negedge clk);
    chk("t4 drop no job", 128'(busy), 128'(0));
    chk("t4 regrant", 128'(req_ready), 128'(2'b10));
    collect("t4", 1'b1, D4, K1, 4);
    req_valid = 2'b00;
    ack("t4");

`ifdef AES_SEQ_TIMEOUT_EN
    // T5: core never answers
    reset_dut();
    core_off = 1'b1; req0_data = D1A; req0_key = K1; req_valid = 2'b01;
    bad = 0;
    while (!aes_en && bad < 20) begin @(negedge clk); bad++; end
    req_valid = 2'b00;
    bad = 0;
    while (!res_valid && bad < 100) begin bad += int'(aes_en); @(negedge clk); end
    chk("t5 run cycles", 128'(bad), 128'(16));
    chk("t5 res_valid", 128'(res_valid), 128'(1));
    chk("t5 res_err", 128'(res_err), 128'(1));
    chk("t5 res_data", res_data, 128'(0));
    chk("t5 res_lat", 128'(res_lat), 128'(16));
    chk("t5 aes_en", 128'(aes_en), 128'(0));
    ack("t5");
    core_off = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
